// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Optional auto-repeat is enabled by defining KEYPAD_AUTOREPEAT_EN.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } kp_state_t;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } frame_class_t;

    localparam logic [3:0] KEY_END_TURN1 = 4'b0011;
    localparam logic [3:0] KEY_END_TURN2 = 4'b0001;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-frame press/release debounce FSM with optional auto-repeat.
// Auto-repeat logic exists only when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_FRAMES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_valid,
    input  logic [1:0] i_frame_class,
    input  logic [3:0] i_frame_code,
    output logic [3:0] o_key_code,
    output logic       o_key_strobe,
    output logic       o_key_held
);

    if (DEBOUNCE < 1 || REPEAT_FRAMES < 1) begin : g_bad_cfg
        $error("keypad_debounce: DEBOUNCE and REPEAT_FRAMES must be >= 1");
    end

    localparam logic [15:0] DB = 16'(DEBOUNCE);

    kp_state_t   r_state;
    logic [15:0] r_cnt;
    logic [3:0]  r_cand;

    logic        w_none;
    logic        w_single;
    logic [15:0] w_cnt_inc;
    logic [15:0] w_press_cnt;
    logic [15:0] w_rel_cnt;

    assign w_none    = i_frame_class == NONE;
    assign w_single  = i_frame_class == SINGLE;
    assign w_cnt_inc = r_cnt + 16'd1;

    // A matching SINGLE extends the run; anything else starts a new one.
    assign w_press_cnt = (r_state == PRESS_WAIT && i_frame_code == r_cand)
                         ? w_cnt_inc : 16'd1;
    assign w_rel_cnt   = (r_state == REL_WAIT) ? w_cnt_inc : 16'd1;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [15:0] RF = 16'(REPEAT_FRAMES);
    logic [15:0] r_rep;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cand       <= '0;
            o_key_code   <= '0;
            o_key_strobe <= 1'b0;
            o_key_held   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep        <= '0;
`endif
        end else begin
            o_key_strobe <= 1'b0;
            if (i_frame_valid) begin
                case (r_state)
                    IDLE, PRESS_WAIT: begin
                        if (w_single) begin
                            r_cand <= i_frame_code;
                            if (w_press_cnt >= DB) begin
                                r_state      <= HELD;
                                r_cnt        <= '0;
                                o_key_code   <= i_frame_code;
                                o_key_strobe <= 1'b1;
                                o_key_held   <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                                r_rep        <= '0;
`endif
                            end else begin
                                r_state <= PRESS_WAIT;
                                r_cnt   <= w_press_cnt;
                            end
                        end else begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    HELD, REL_WAIT: begin
                        if (w_none) begin
                            if (w_rel_cnt >= DB) begin
                                r_state    <= IDLE;
                                r_cnt      <= '0;
                                o_key_held <= 1'b0;
                            end else begin
                                r_state <= REL_WAIT;
                                r_cnt   <= w_rel_cnt;
                            end
                        end else begin
                            r_state <= HELD;
                            r_cnt   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            // Only frames that stay in HELD advance repeat.
                            if (r_state == HELD) begin
                                if (r_rep + 16'd1 >= RF) begin
                                    r_rep        <= '0;
                                    o_key_strobe <= 1'b1;
                                end else begin
                                    r_rep <= r_rep + 16'd1;
                                end
                            end
`endif
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner, row synchronizer and frame classifier.
// Define KEYPAD_AUTOREPEAT_EN to enable held-key repeat strobes.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_FRAMES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_strobe,
    output logic       key_held
);

    if (SCAN_DIV < 4) begin : g_bad_div
        $error("keypad_scanner: SCAN_DIV must be >= 4");
    end

    localparam int             SW        = $clog2(SCAN_DIV);
    localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [SW-1:0] r_slot;
    logic [1:0]    r_col;
    logic [3:0]    r_col_n;
    logic [1:0]    r_hits;
    logic [3:0]    r_code;

    logic       w_tc;
    logic [3:0] w_act;
    logic [2:0] w_pop;
    logic [2:0] w_sum;
    logic [1:0] w_row;
    logic       w_frame_valid;
    logic [1:0] w_class;
    logic [3:0] w_code;

    assign w_tc  = r_slot == SLOT_LAST;
    assign w_act = ~r_sync2;
    assign w_pop = popcount4(w_act);
    assign w_sum = {1'b0, r_hits} + w_pop;
    assign w_row = w_act[1] ? 2'd1 :
                   w_act[2] ? 2'd2 :
                   w_act[3] ? 2'd3 : 2'd0;

    // Column 3's sample closes the frame, so classify it combinationally.
    assign w_frame_valid = w_tc && (r_col == 2'd3);
    assign w_class = (w_sum == 3'd0) ? NONE :
                     (w_sum == 3'd1) ? SINGLE : MULTI;
    assign w_code  = (w_pop == 3'd1) ? {w_row, r_col} : r_code;

    assign col_n = r_col_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= row_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot  <= '0;
            r_col   <= 2'd0;
            r_col_n <= 4'b1110;
            r_hits  <= 2'd0;
            r_code  <= 4'd0;
        end else if (w_tc) begin
            r_slot  <= '0;
            r_col   <= r_col + 2'd1;
            r_col_n <= ~(4'b0001 << (r_col + 2'd1));
            if (r_col == 2'd3) begin
                r_hits <= 2'd0;
                r_code <= 4'd0;
            end else begin
                r_hits <= (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
                if (w_pop == 3'd1) begin
                    r_code <= {w_row, r_col};
                end
            end
        end else begin
            r_slot <= r_slot + 1'b1;
        end
    end

    keypad_debounce #(
        .DEBOUNCE      (DEBOUNCE),
        .REPEAT_FRAMES (REPEAT_FRAMES)
    ) u_debounce (
        .clk           (clk),
        .rst           (rst),
        .i_frame_valid (w_frame_valid),
        .i_frame_class (w_class),
        .i_frame_code  (w_code),
        .o_key_code    (key_code),
        .o_key_strobe  (key_strobe),
        .o_key_held    (key_held)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
// Define KEYPAD_AUTOREPEAT_EN to also cover the repeat strobes.
module tb_keypad_scanner;

    localparam int FRAME = 16;

    typedef struct {
        logic [15:0] mask;
        int          frames;
        int          strobes;
        logic [3:0]  code;
        logic        held;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_strobe;
    logic        key_held;
    logic [15:0] press = '0;

    int checks = 0;
    int errors = 0;

    vec_t tbl[$];

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE      (2),
        .REPEAT_FRAMES (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_n      (row_n),
        .col_n      (col_n),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    // Pressed key at (r,c) shorts row r to column c.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (press[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    function automatic logic [15:0] k(input int r, input int c);
        logic [15:0] one;
        one = 16'd1;
        return one << (r * 4 + c);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frames(input int n, output int s);
        s = 0;
        repeat (FRAME * n) begin
            @(negedge clk);
            if (key_strobe) s++;
        end
    endtask

    task automatic add(input logic [15:0] m, input int f, input int s,
                       input logic [3:0] c, input logic h);
        vec_t v;
        v.mask = m; v.frames = f; v.strobes = s; v.code = c; v.held = h;
        tbl.push_back(v);
    endtask

    initial begin
        int s;
        logic [15:0] rep_mask;
        logic [15:0] rep_exp;
        logic [3:0]  exp_col;

        // clean press of (0,3)
        add(k(0,3), 1, 0, 4'b0000, 1'b0);
        add(k(0,3), 1, 1, 4'b0011, 1'b1);
        add(k(0,3), 2, 0, 4'b0011, 1'b1);
        // release glitch then real release
        add(16'h0,  1, 0, 4'b0011, 1'b1);
        add(k(0,3), 1, 0, 4'b0011, 1'b1);
        add(16'h0,  1, 0, 4'b0011, 1'b1);
        add(16'h0,  1, 0, 4'b0011, 1'b0);
        // bounce of (2,1), then stable
        for (int i = 0; i < 6; i++)
            add((i % 2 == 0) ? k(2,1) : 16'h0, 1, 0, 4'b0011, 1'b0);
        add(k(2,1), 1, 0, 4'b0011, 1'b0);
        add(k(2,1), 1, 1, 4'b1001, 1'b1);
        add(16'h0,  2, 0, 4'b1001, 1'b0);
        // multi-key, then one released
        add(k(0,1) | k(3,2), 3, 0, 4'b1001, 1'b0);
        add(k(0,1), 2, 1, 4'b0001, 1'b1);
        add(16'h0,  2, 0, 4'b0001, 1'b0);
        // candidate change restarts debounce
        add(k(1,0), 1, 0, 4'b0001, 1'b0);
        add(k(1,1), 1, 0, 4'b0001, 1'b0);
        add(k(1,1), 1, 1, 4'b0101, 1'b1);
        // second key while held is ignored
        add(k(1,1) | k(2,2), 1, 0, 4'b0101, 1'b1);
        add(k(2,2), 1, 0, 4'b0101, 1'b1);
        add(16'h0,  2, 0, 4'b0101, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check("reset col_n", 32'(col_n), 32'(4'b1110));
        check("reset key_code", 32'(key_code), 32'd0);
        check("reset key_strobe", 32'(key_strobe), 32'd0);
        check("reset key_held", 32'(key_held), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i % 4 == 1) begin
                exp_col = ~(4'b0001 << (i / 4));
                check($sformatf("col_n slot%0d", i / 4),
                      32'(col_n), 32'(exp_col));
            end
        end

        foreach (tbl[i]) begin
            press = tbl[i].mask;
            run_frames(tbl[i].frames, s);
            check($sformatf("step%0d strobes", i), 32'(s),
                  32'(tbl[i].strobes));
            check($sformatf("step%0d key_code", i), 32'(key_code),
                  32'(tbl[i].code));
            check($sformatf("step%0d key_held", i), 32'(key_held),
                  32'(tbl[i].held));
        end

        // held key: repeat strobes only with auto-repeat
        press = KEY_CODE_PRESS();
        run_frames(2, s);
        check("hold accept strobes", 32'(s), 32'd1);
        check("hold accept code", 32'(key_code), 32'(4'b0011));
        rep_mask = '0;
        for (int f = 1; f <= 10; f++) begin
            run_frames(1, s);
            rep_mask[f] = (s != 0);
            if (s > 1) check($sformatf("hold frame%0d", f), 32'(s), 32'd1);
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_exp = 16'h0248;
`else
        rep_exp = 16'h0000;
`endif
        check("hold repeat frames", 32'(rep_mask), 32'(rep_exp));
        check("hold key_held", 32'(key_held), 32'd1);
        check("hold key_code", 32'(key_code), 32'(4'b0011));

        // asynchronous reset mid-frame
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst col_n", 32'(col_n), 32'(4'b1110));
        check("midrst key_code", 32'(key_code), 32'd0);
        check("midrst key_strobe", 32'(key_strobe), 32'd0);
        check("midrst key_held", 32'(key_held), 32'd0);
        @(negedge clk);
        press = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("restart col0", 32'(col_n), 32'(4'b1110));
        @(negedge clk);
        check("restart col1", 32'(col_n), 32'(4'b1101));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    function automatic logic [15:0] KEY_CODE_PRESS();
        return k(0, 3);
    endfunction

endmodule
